// File: rtl/motor_link_supervisor.sv
// Motor link supervisor: gates the GBT RX motor stream behind a feedback interlock.
// Build option MOTOR_LINK_AUTORECOVER_EN: FAULT exits after holdoff without clear_fault_i.
package motor_link_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    localparam logic [31:0] GEFE_INTERLOCK = 32'h6EFE_C0DE;
endpackage

module motor_link_supervisor
    import motor_link_pkg::*;
#(
    parameter int          g_ArmFrames     = 16,
    parameter int          g_TimeoutCycles = 4000,
    parameter int          g_HoldoffCycles = 40000,
    parameter logic [31:0] g_Interlock     = GEFE_INTERLOCK
) (
    input  ckrs_t        ClkRs_ix,
    input  logic         rx_ready_i,
    input  logic         rx_clken_i,
    input  logic [31:0]  feedback_ib32,
    input  logic         feedback_new_i,
    input  logic [63:0]  motor_data_ib64,
    input  logic [15:0]  mem_data_ib16,
    input  logic         force_off_i,
    input  logic         clear_fault_i,
    output logic [63:0]  motorControl_ob64,
    output logic [15:0]  mem_data_ob16,
    output logic         mem_valid_o,
    output logic [1:0]   state_ob2,
    output logic         link_active_o,
    output logic [15:0]  fault_count_ob16
);

    localparam int AW = $clog2(g_ArmFrames + 1);
    localparam int WW = $clog2(g_TimeoutCycles + 1);
    localparam int HW = $clog2(g_HoldoffCycles + 1);

    localparam logic [AW-1:0] ARM_LAST = AW'(g_ArmFrames - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(g_TimeoutCycles - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(g_HoldoffCycles);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ACTIVE = 2'd2,
        FAULT  = 2'd3
    } state_t;

    logic          clk;
    logic          rst;
    logic          match;
    logic          exit_ok;
    logic          stay_active;
    logic          fwd;
    logic          fault_entry;
    state_t        state;
    state_t        state_next;
    logic [AW-1:0] arm_cnt;
    logic [WW-1:0] wd_cnt;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   fault_cnt;

    assign clk   = ClkRs_ix.clk;
    assign rst   = ClkRs_ix.reset;
    assign match = rx_ready_i && (feedback_ib32 == g_Interlock);

`ifdef MOTOR_LINK_AUTORECOVER_EN
    logic unused_clear;
    assign unused_clear = clear_fault_i;
    assign exit_ok      = 1'b1;
`else
    assign exit_ok = clear_fault_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (force_off_i) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (match) state_next = ARMING;
                end
                ARMING: begin
                    if (!match) begin
                        state_next = IDLE;
                    end else if (rx_clken_i && arm_cnt == ARM_LAST) begin
                        state_next = ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A feedback pulse in the timeout cycle keeps the link up
                    if (!match || (!feedback_new_i && wd_cnt == WD_LAST)) begin
                        state_next = FAULT;
                    end
                end
                FAULT: begin
                    if (hold_cnt == HOLD_MAX && exit_ok) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        link_active_o = (state == ACTIVE);
        stay_active   = (state == ACTIVE) && (state_next == ACTIVE);
        fwd           = stay_active && rx_clken_i;
        fault_entry   = (state == ACTIVE) && (state_next == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt   <= '0;
            wd_cnt    <= '0;
            hold_cnt  <= '0;
            fault_cnt <= '0;
        end else begin
            if (state != ARMING) begin
                arm_cnt <= '0;
            end else if (rx_clken_i && match && arm_cnt != ARM_LAST) begin
                arm_cnt <= arm_cnt + 1'b1;
            end

            if (state != ACTIVE || feedback_new_i) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LAST) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (state != FAULT) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (fault_entry && fault_cnt != 16'hFFFF) begin
                fault_cnt <= fault_cnt + 1'b1;
            end
        end
    end

    // Motors are released only while the link stays ACTIVE
    always_ff @(posedge clk) begin
        if (rst) begin
            motorControl_ob64 <= '1;
            mem_data_ob16     <= '0;
            mem_valid_o       <= 1'b0;
        end else begin
            mem_valid_o <= fwd;
            if (fwd) begin
                motorControl_ob64 <= motor_data_ib64;
                mem_data_ob16     <= mem_data_ib16;
            end else if (!stay_active) begin
                motorControl_ob64 <= '1;
            end
        end
    end

    assign state_ob2        = state;
    assign fault_count_ob16 = fault_cnt;

endmodule

// File: tb/tb_motor_link_supervisor.sv
// Bench for motor_link_supervisor: directed steps plus random traffic
// against a frame/cycle-count reference model.
module tb_motor_link_supervisor;
    import motor_link_pkg::*;

    localparam int ARM  = 16;
    localparam int TO   = 8;
    localparam int HOLD = 20;
    localparam logic [31:0] IL = GEFE_INTERLOCK;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef MOTOR_LINK_AUTORECOVER_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ckrs_t       clk_rs;
    logic        rdy = 1'b0;
    logic        clken = 1'b0;
    logic [31:0] fb = '0;
    logic        fbnew = 1'b0;
    logic [63:0] mdata = '0;
    logic [15:0] mem_in = '0;
    logic        force_off = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] mot;
    logic [15:0] mem_out;
    logic        mem_valid;
    logic [1:0]  state;
    logic        link_active;
    logic [15:0] fc;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: mode 0 idle, 1 arming, 2 active, 3 fault
    int          m_state = 0;
    logic [63:0] m_mot = ONES;
    logic [15:0] m_mem = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_fc = '0;
    int          m_streak = 0;
    int          m_quiet = 0;
    int          m_held = 0;

    assign clk_rs = {clk, rst};

    always #5 clk = ~clk;

    motor_link_supervisor #(
        .g_ArmFrames     (ARM),
        .g_TimeoutCycles (TO),
        .g_HoldoffCycles (HOLD),
        .g_Interlock     (IL)
    ) dut (
        .ClkRs_ix          (clk_rs),
        .rx_ready_i        (rdy),
        .rx_clken_i        (clken),
        .feedback_ib32     (fb),
        .feedback_new_i    (fbnew),
        .motor_data_ib64   (mdata),
        .mem_data_ib16     (mem_in),
        .force_off_i       (force_off),
        .clear_fault_i     (clear),
        .motorControl_ob64 (mot),
        .mem_data_ob16     (mem_out),
        .mem_valid_o       (mem_valid),
        .state_ob2         (state),
        .link_active_o     (link_active),
        .fault_count_ob16  (fc)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit m;
        int elapsed;
        m = rdy && (fb == IL);
        if (rst) begin
            m_state = 0;
            m_mot = ONES;
            m_mem = '0;
            m_valid = 1'b0;
            m_fc = '0;
            return;
        end
        m_valid = 1'b0;
        if (force_off) begin
            m_state = 0;
            m_mot = ONES;
            return;
        end
        case (m_state)
            0: if (m) begin
                m_state = 1;
                m_streak = 0;
            end
            1: if (!m) begin
                m_state = 0;
            end else if (clken) begin
                m_streak++;
                if (m_streak == ARM) begin
                    m_state = 2;
                    m_quiet = 0;
                end
            end
            2: begin
                elapsed = m_quiet + 1;
                if (!m || (!fbnew && elapsed >= TO)) begin
                    m_state = 3;
                    m_held = 0;
                    m_mot = ONES;
                    if (m_fc != 16'hFFFF) m_fc++;
                end else begin
                    m_quiet = fbnew ? 0 : elapsed;
                    if (clken) begin
                        m_mot = mdata;
                        m_mem = mem_in;
                        m_valid = 1'b1;
                    end
                end
            end
            default: begin
                if (m_held >= HOLD && (AUTO || clear)) m_state = 0;
                else m_held++;
            end
        endcase
    endtask

    task automatic check_all();
        chk("state", 64'(state), 64'(m_state));
        chk("link_active", 64'(link_active), 64'(m_state == 2));
        chk("motor", mot, m_mot);
        chk("mem_data", 64'(mem_out), 64'(m_mem));
        chk("mem_valid", 64'(mem_valid), 64'(m_valid));
        chk("fault_count", 64'(fc), 64'(m_fc));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic strobe();
        clken = 1'b1;
        fbnew = 1'b1;
        mdata = {$urandom, $urandom};
        mem_in = 16'($urandom);
    endtask

    task automatic quiet();
        clken = 1'b0;
        fbnew = 1'b0;
    endtask

    initial begin
        logic [63:0] first;

        repeat (2) tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_motor", mot, ONES);
        chk("rst_fc", 64'(fc), 64'd0);
        rst = 1'b0;

        // arm with a strobe every third cycle
        rdy = 1'b1;
        fb = IL;
        tick();
        chk("arming_entry", 64'(state), 64'd1);
        for (int i = 1; i <= ARM; i++) begin
            strobe();
            tick();
            chk("arm_progress", 64'(state), (i == ARM) ? 64'd2 : 64'd1);
            quiet();
            tick();
            tick();
        end
        chk("active_idle_motor", mot, ONES);
        chk("active_idle_valid", 64'(mem_valid), 64'd0);
        strobe();
        first = mdata;
        tick();
        chk("first_frame", mot, first);
        chk("first_valid", 64'(mem_valid), 64'd1);
        quiet();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            strobe();
            tick();
            quiet();
            tick();
            tick();
        end

        // watchdog expiry
        fbnew = 1'b1;
        tick();
        fbnew = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk("wd_expire", 64'(state), (k == TO) ? 64'd3 : 64'd2);
        end
        chk("wd_fc", 64'(fc), 64'd1);
        chk("wd_motor", mot, ONES);

        // holdoff: early clear ignored, late clear accepted
        for (int k = 1; k <= HOLD + 1; k++) begin
            clear = (k == 5) || (k >= HOLD);
            tick();
            chk("holdoff", 64'(state), (k <= HOLD) ? 64'd3 : 64'd0);
        end
        clear = 1'b0;
        tick();

        // arm abort on the tenth frame
        for (int i = 1; i <= 10; i++) begin
            fb = (i == 10) ? ~IL : IL;
            strobe();
            tick();
            chk("abort", 64'(state), (i == 10) ? 64'd0 : 64'd1);
            quiet();
            fb = IL;
            tick();
            tick();
        end
        for (int i = 1; i <= ARM; i++) begin
            strobe();
            tick();
            chk("rearm", 64'(state), (i == ARM) ? 64'd2 : 64'd1);
            quiet();
            tick();
            tick();
        end

        // feedback pulse in the timeout cycle keeps ACTIVE
        fbnew = 1'b1;
        tick();
        fbnew = 1'b0;
        repeat (TO - 1) tick();
        fbnew = 1'b1;
        tick();
        chk("wd_rescue", 64'(state), 64'd2);
        fbnew = 1'b0;

        force_off = 1'b1;
        tick();
        chk("force_state", 64'(state), 64'd0);
        chk("force_fc", 64'(fc), 64'd1);
        force_off = 1'b0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(299) != 0);
            fb = ($urandom_range(299) != 0) ? IL : $urandom;
            clken = ($urandom_range(2) == 0);
            fbnew = ($urandom_range(3) == 0);
            force_off = ($urandom_range(499) == 0);
            clear = $urandom_range(1) == 1;
            mdata = {$urandom, $urandom};
            mem_in = 16'($urandom);
            tick();
        end

        // fault counter saturation
        rdy = 1'b1;
        fb = IL;
        quiet();
        clear = 1'b0;
        force_off = 1'b1;
        tick();
        force_off = 1'b0;
        m_fc = 16'hFFFE;
        force dut.fault_cnt = 16'hFFFE;
        #1;
        release dut.fault_cnt;
        for (int r = 0; r < 2; r++) begin
            tick();
            for (int i = 0; i < ARM; i++) begin
                strobe();
                tick();
            end
            quiet();
            fb = ~IL;
            tick();
            fb = IL;
            chk("sat_state", 64'(state), 64'd3);
            chk("sat_fc", 64'(fc), 64'hFFFF);
            if (r == 0) begin
                clear = 1'b1;
                repeat (HOLD + 1) tick();
                chk("sat_exit", 64'(state), 64'd0);
                clear = 1'b0;
            end
        end

        // reset while in FAULT
        rst = 1'b1;
        tick();
        chk("rst2_state", 64'(state), 64'd0);
        chk("rst2_link", 64'(link_active), 64'd0);
        chk("rst2_motor", mot, ONES);
        chk("rst2_mem", 64'(mem_out), 64'd0);
        chk("rst2_valid", 64'(mem_valid), 64'd0);
        chk("rst2_fc", 64'(fc), 64'd0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/motor_link_supervisor.md
Name: motor_link_supervisor

Overview:
Controller gating the GBT-received motor control stream to the stepper drivers. It arms only after the serial feedback loop shows the interlock word for a number of consecutive frames. While ACTIVE it watchdogs the feedback link and forces all motors deactivated on any loss. It replaces the single-cycle interlock compare in the application layer and runs in the GBT RX frame clock domain.

Parameters:
g_ArmFrames, 16, consecutive rx_clken frames with interlock match required to enter ACTIVE (>=1)
g_TimeoutCycles, 4000, max clock cycles between feedback_new_i pulses while ACTIVE
g_HoldoffCycles, 40000, minimum cycles spent in FAULT before exit is allowed
g_Interlock, GEFE_INTERLOCK, 32-bit expected feedback word

Ports:
ClkRs_ix  input  ckrs_t (.clk, .reset)  one clock; reset is synchronous and active-high
rx_ready_i  input  1  GBT RX link ready
rx_clken_i  input  1  frame strobe, one cycle per received frame
feedback_ib32  input  32  word from the feedback serial register
feedback_new_i  input  1  single-cycle pulse, new feedback word arrived
motor_data_ib64  input  64  received motor control bits
mem_data_ib16  input  16  received rx_memory stream
force_off_i  input  1  software/debug kill, level
clear_fault_i  input  1  fault acknowledge, level
motorControl_ob64  output  64  gated motor controls
mem_data_ob16  output  16  gated rx_memory data
mem_valid_o  output  1  one-cycle strobe with mem_data_ob16
state_ob2  output  2  IDLE=0, ARMING=1, ACTIVE=2, FAULT=3
link_active_o  output  1  high iff state ACTIVE
fault_count_ob16  output  16  saturating count of ACTIVE->FAULT transitions

Behaviour:
- match = rx_ready_i && (feedback_ib32 == g_Interlock).
- Reset: state IDLE, motorControl_ob64 = all ones (StepDeactivate set on every motor), mem_data_ob16 = 0, mem_valid_o = 0, link_active_o = 0, fault_count_ob16 = 0, all counters 0.
- Priority: reset > force_off_i > the transition rules below.
- force_off_i high in any state: next state IDLE. Outputs forced to all ones. fault_count not incremented.
- IDLE -> ARMING when match. arm_cnt cleared.
- ARMING: arm_cnt increments on each rx_clken_i with match. Any cycle with !match returns to IDLE. When arm_cnt reaches g_ArmFrames-1 and a further matching rx_clken_i arrives, go to ACTIVE; this is the g_ArmFrames-th match. wd_cnt cleared on entry.
- ACTIVE:
  - wd_cnt increments every cycle and clears on feedback_new_i.
  - Exit to FAULT on any of: !match, or wd_cnt == g_TimeoutCycles-1 without feedback_new_i that cycle.
  - feedback_new_i and a timeout in the same cycle: the pulse wins and ACTIVE is held.
  - On FAULT entry: fault_count_ob16 +1, saturating at 16'hFFFF. hold_cnt cleared.
- FAULT: hold_cnt increments and saturates at g_HoldoffCycles. Exit to IDLE requires hold_cnt == g_HoldoffCycles and clear_fault_i. clear_fault_i during holdoff is ignored, not remembered.
- Datapath, registered with 1-cycle latency:
  - In ACTIVE with rx_clken_i: motorControl_ob64 <= motor_data_ib64, mem_data_ob16 <= mem_data_ib16, mem_valid_o = 1 next cycle.
  - In ACTIVE without rx_clken_i: outputs hold.
  - The rx_clken_i in the cycle that enters ACTIVE is not forwarded.
- Leaving ACTIVE: motorControl_ob64 becomes all ones in the same registered update as the state change. mem_valid_o = 0. mem_data_ob16 holds its last value.
- Outside ACTIVE: motorControl_ob64 stays all ones and mem_valid_o stays 0.
- Counter widths: $clog2(param+1). No wrap is possible; all counters saturate or clear.

Optional Feature:
MOTOR_LINK_AUTORECOVER_EN
- Defined: FAULT exits to IDLE automatically when hold_cnt reaches g_HoldoffCycles. clear_fault_i is ignored.
- Undefined: clear_fault_i is required after holdoff, as described in Behaviour.

Test Plan:
- Arm: reset released, rx_ready=1, feedback=g_Interlock, rx_clken every 3 cycles.
  - ARMING after 1 cycle, ACTIVE after 16 strobes.
  - First forwarded frame appears 1 cycle after the next strobe; outputs all ones before that.
- Arm abort: mismatch injected on the 10th frame -> IDLE. Next match restarts from arm_cnt 0 and needs 16 fresh frames.
- Watchdog (g_TimeoutCycles=8): ACTIVE, feedback_new_i withheld.
  - FAULT after exactly 8 cycles, motorControl_ob64 = 64'hFFFF_FFFF_FFFF_FFFF, fault_count = 1.
  - Repeat with feedback_new_i on cycle 8: stays ACTIVE.
- Holdoff (g_HoldoffCycles=20):
  - clear_fault_i pulsed at cycle 5 of FAULT: stays FAULT.
  - clear_fault_i held from cycle 20: IDLE.
  - With MOTOR_LINK_AUTORECOVER_EN: IDLE at cycle 20 without clear.
- Force/reset mid-operation:
  - force_off_i in ACTIVE: IDLE next cycle, fault_count unchanged.
  - Reset asserted in FAULT with fault_count = 16'hFFFF: all outputs return to reset values.
  - Saturation check: 16'hFFFF fault_count plus one more fault stays at 16'hFFFF.
